// File: rtl/ag_pkg.sv
// Shared definitions for the sensor logger: trend codes and the debouncer reset level.
package ag_pkg;

    localparam logic [1:0] TREND_FLAT = 2'b00;
    localparam logic [1:0] TREND_UP   = 2'b01;
    localparam logic [1:0] TREND_DOWN = 2'b10;
    localparam logic [1:0] TREND_NONE = 2'b11;

    // Mid-scale code for a w-bit sample, used as the neutral power-up value.
    function automatic int unsigned mid_value(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/ag_debounce.sv
// Per-channel debouncer: the output follows the input only after it has held
// the same code for FILT_CNT+2 consecutive enabled clocks.
module ag_debounce
    import ag_pkg::*;
#(
    parameter int W        = 2,
    parameter int FILT_CNT = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ena,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_filt
);
    localparam int             CW      = $clog2(FILT_CNT + 1);
    localparam logic [W-1:0]   MID     = W'(mid_value(W));
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_CNT);

    logic [W-1:0]  r_prev;
    logic [W-1:0]  r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= MID;
            r_filt <= MID;
            r_cnt  <= '0;
        end else if (i_ena) begin
            if (i_in != r_prev) begin
                r_prev <= i_in;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_filt <= i_in;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/ag_sensor_logger.sv
// Debounced multi-channel sensor logger: periodic snapshots into a ring buffer
// with overwrite-on-full, per-channel min/max statistics and trend codes.
module ag_sensor_logger
    import ag_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int W            = 2,
    parameter int FILT_CNT     = 100000,
    parameter int LOG_INTERVAL = 2500000,
    parameter int DEPTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [N_CH*W-1:0]      sens_in,
    input  logic                   clear,
    output logic [N_CH*W-1:0]      filt_out,
    output logic                   log_tick,
    input  logic                   rd_req,
    output logic                   rd_valid,
    output logic [N_CH*W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic [N_CH*W-1:0]      min_out,
    output logic [N_CH*W-1:0]      max_out,
    output logic [2*N_CH-1:0]      trend_out
);
    localparam int            VW     = N_CH * W;
    localparam int            AW     = $clog2(DEPTH);
    localparam int            CW     = AW + 1;
    localparam int            TW     = $clog2(LOG_INTERVAL);
    localparam logic [TW-1:0] T_LAST = TW'(LOG_INTERVAL - 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);

    logic [TW-1:0]     r_timer;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_stat_valid;
    logic              r_rd_valid_p1;
    logic [VW-1:0]     r_rd_data_p1;
    logic [VW-1:0]     r_min;
    logic [VW-1:0]     r_max;
    logic [VW-1:0]     r_last;
    logic [2*N_CH-1:0] r_trend;
    logic [VW-1:0]     r_mem [DEPTH];
    logic              w_pop;
    logic              w_full;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ag_debounce #(.W(W), .FILT_CNT(FILT_CNT)) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_ena  (ena),
            .i_in   (sens_in[k*W +: W]),
            .o_filt (filt_out[k*W +: W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timer <= '0;
        else if (ena)
            r_timer <= (r_timer == T_LAST) ? '0 : r_timer + 1'b1;
    end

    assign log_tick = ena && (r_timer == T_LAST);
    assign w_pop    = rd_req && (r_count != '0);
    assign w_full   = (r_count == FULL);

    // Control: pointers, occupancy, flags and trend codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            r_stat_valid  <= 1'b0;
            r_rd_valid_p1 <= 1'b0;
            r_rd_data_p1  <= '0;
            r_trend       <= {N_CH{TREND_NONE}};
        end else begin
            r_rd_valid_p1 <= 1'b0;
            if (clear) begin
                r_wptr       <= '0;
                r_rptr       <= '0;
                r_count      <= '0;
                r_ovf        <= 1'b0;
                r_stat_valid <= 1'b0;
                r_trend      <= {N_CH{TREND_NONE}};
            end else begin
                if (w_pop) begin
                    r_rd_valid_p1 <= 1'b1;
                    r_rd_data_p1  <= r_mem[r_rptr];
                end
                // A log into a full buffer with no pop evicts the oldest entry.
                if (w_pop || (log_tick && w_full))
                    r_rptr <= r_rptr + 1'b1;
                if (log_tick && !w_pop && !w_full)
                    r_count <= r_count + 1'b1;
                else if (w_pop && !log_tick)
                    r_count <= r_count - 1'b1;
                if (log_tick && w_full && !w_pop)
                    r_ovf <= 1'b1;
                if (log_tick) begin
                    r_wptr       <= r_wptr + 1'b1;
                    r_stat_valid <= 1'b1;
                    for (int c = 0; c < N_CH; c++) begin
                        if (!r_stat_valid)
                            r_trend[2*c +: 2] <= TREND_NONE;
                        else if (filt_out[c*W +: W] > r_last[c*W +: W])
                            r_trend[2*c +: 2] <= TREND_UP;
                        else if (filt_out[c*W +: W] < r_last[c*W +: W])
                            r_trend[2*c +: 2] <= TREND_DOWN;
                        else
                            r_trend[2*c +: 2] <= TREND_FLAT;
                    end
                end
            end
        end
    end

    // Data: buffer storage and statistics, qualified by r_stat_valid.
    always_ff @(posedge clk) begin
        if (log_tick && !clear) begin
            r_mem[r_wptr] <= filt_out;
            r_last        <= filt_out;
            for (int c = 0; c < N_CH; c++) begin
                if (!r_stat_valid || (filt_out[c*W +: W] < r_min[c*W +: W]))
                    r_min[c*W +: W] <= filt_out[c*W +: W];
                if (!r_stat_valid || (filt_out[c*W +: W] > r_max[c*W +: W]))
                    r_max[c*W +: W] <= filt_out[c*W +: W];
            end
        end
    end

    assign rd_valid  = r_rd_valid_p1;
    assign rd_data   = r_rd_data_p1;
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign trend_out = r_trend;
    assign min_out   = r_stat_valid ? r_min : '0;
    assign max_out   = r_stat_valid ? r_max : '0;

endmodule

// File: tb/tb_ag_sensor_logger.sv
// Randomised and directed bench for ag_sensor_logger with a queue-based reference model.
module tb_ag_sensor_logger;
    localparam int N_CH  = 4;
    localparam int W     = 2;
    localparam int FC    = 4;
    localparam int LI    = 8;
    localparam int DEPTH = 4;
    localparam int VW    = N_CH * W;
    localparam int MID   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena = 1'b0;
    logic          clear = 1'b0;
    logic          rd_req = 1'b0;
    logic [VW-1:0] sens_in = '0;
    logic [VW-1:0] filt_out, rd_data, min_out, max_out;
    logic          log_tick, rd_valid, ovf;
    logic [2:0]    count;
    logic [7:0]    trend_out;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int            m_ecnt;
    int            m_run_val [N_CH];
    int            m_run_len [N_CH];
    int            m_filt    [N_CH];
    int            m_min     [N_CH];
    int            m_max     [N_CH];
    int            m_last    [N_CH];
    int            m_trend   [N_CH];
    bit            m_have, m_ovf, m_rdv;
    logic [VW-1:0] m_q[$];
    logic [VW-1:0] exp_q[$];

    ag_sensor_logger #(
        .N_CH(N_CH), .W(W), .FILT_CNT(FC), .LOG_INTERVAL(LI), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sens_in(sens_in), .clear(clear),
        .filt_out(filt_out), .log_tick(log_tick), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .ovf(ovf),
        .min_out(min_out), .max_out(max_out), .trend_out(trend_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [VW-1:0] pack(input int a [N_CH]);
        logic [VW-1:0] v = '0;
        for (int c = 0; c < N_CH; c++) v[c*W +: W] = W'(a[c]);
        return v;
    endfunction

    function automatic logic [7:0] pack_trend();
        logic [7:0] v = '0;
        for (int c = 0; c < N_CH; c++) v[2*c +: 2] = 2'(m_trend[c]);
        return v;
    endfunction

    task automatic model_reset();
        m_ecnt = 0; m_have = 0; m_ovf = 0; m_rdv = 0;
        m_q.delete(); exp_q.delete();
        for (int c = 0; c < N_CH; c++) begin
            m_run_val[c] = MID; m_run_len[c] = 1; m_filt[c] = MID; m_trend[c] = 3;
        end
    endtask

    task automatic model_step();
        bit            tick;
        logic [VW-1:0] snap;
        int            s;
        tick  = ena && (m_ecnt % LI == LI - 1);
        snap  = pack(m_filt);
        m_rdv = 0;
        if (clear) begin
            m_q.delete(); m_ovf = 0; m_have = 0;
            for (int c = 0; c < N_CH; c++) m_trend[c] = 3;
        end else begin
            if (rd_req && m_q.size() > 0) begin
                exp_q.push_back(m_q.pop_front());
                m_rdv = 1;
            end
            if (tick) begin
                if (m_q.size() == DEPTH) begin
                    void'(m_q.pop_front());
                    m_ovf = 1;
                end
                m_q.push_back(snap);
                for (int c = 0; c < N_CH; c++) begin
                    s = m_filt[c];
                    if (!m_have) begin
                        m_min[c] = s; m_max[c] = s; m_trend[c] = 3;
                    end else begin
                        if (s < m_min[c]) m_min[c] = s;
                        if (s > m_max[c]) m_max[c] = s;
                        m_trend[c] = (s > m_last[c]) ? 1 : (s < m_last[c]) ? 2 : 0;
                    end
                    m_last[c] = s;
                end
                m_have = 1;
            end
        end
        if (ena) begin
            m_ecnt++;
            for (int c = 0; c < N_CH; c++) begin
                s = int'(sens_in[c*W +: W]);
                if (s == m_run_val[c]) m_run_len[c]++;
                else begin m_run_val[c] = s; m_run_len[c] = 1; end
                // A value counts once it has been seen on FC+2 consecutive enabled edges.
                if (m_run_len[c] >= FC + 2) m_filt[c] = m_run_val[c];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: compares every output on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL rd_data: actual %0h required none (no pop expected) at %0t", rd_data, $time);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
            check("rd_valid", rd_valid, m_rdv);
            check("filt_out", filt_out, pack(m_filt));
            check("log_tick", log_tick, ena && (m_ecnt % LI == LI - 1));
            check("count", count, m_q.size());
            check("ovf", ovf, m_ovf);
            check("min_out", min_out, m_have ? pack(m_min) : '0);
            check("max_out", max_out, m_have ? pack(m_max) : '0);
            check("trend_out", trend_out, pack_trend());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int c, input int v);
        sens_in[c*W +: W] = W'(v);
    endtask

    task automatic wait_tick();
        int k = 0;
        while (log_tick !== 1'b1 && k < 4 * LI) begin
            step(1);
            k++;
        end
        if (log_tick !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL wait_tick: log_tick actual %0b required 1 within %0d cycles", log_tick, 4 * LI);
        end
    endtask

    initial begin
        int seq [4] = '{2, 2, 0, 0};
        sens_in = {N_CH{2'd2}};
        #1 rst_n = 1'b0;
        step(2);
        check("rst_count", count, 0);
        check("rst_filt", filt_out, 8'hAA);
        check("rst_trend", trend_out, 8'hFF);
        check("rst_min", min_out, 0);
        check("rst_ovf", ovf, 0);

        // Debounce: stable 3 on ch0 appears after six edges; a 3-cycle glitch is ignored.
        rst_n = 1'b1; ena = 1'b1; set_ch(0, 3);
        step(5);
        check("deb_before", filt_out[1:0], 2);
        step(1);
        check("deb_after", filt_out[1:0], 3);
        set_ch(0, 0); step(3); set_ch(0, 3); step(8);
        check("deb_glitch", filt_out[1:0], 3);

        // Clear on a tick, then log ch0 = 1,2,2,0.
        wait_tick(); clear = 1'b1; set_ch(0, 1); step(1); clear = 1'b0;
        check("clr_count", count, 0);
        check("clr_trend", trend_out, 8'hFF);
        check("clr_max", max_out, 0);
        for (int i = 0; i < 4; i++) begin
            wait_tick(); set_ch(0, seq[i]); step(1);
            if (i == 0) check("first_min", min_out, 8'hA9);
        end
        check("seq_count", count, 4);
        check("seq_min", min_out, 8'hA8);
        check("seq_max", max_out, 8'hAA);
        check("seq_trend", trend_out, 8'h02);
        rd_req = 1'b1;
        step(1); check("pop1", rd_data, 8'hA9);
        step(1); check("pop2", rd_data, 8'hAA);
        step(1); check("pop3", rd_data, 8'hAA);
        step(1); check("pop4", rd_data, 8'hA8); check("pop4_v", rd_valid, 1);
        rd_req = 1'b0; step(1);
        check("pop_done", count, 0);

        // Five logs without reads overwrite the oldest entry.
        for (int i = 0; i < 5; i++) begin
            wait_tick(); set_ch(0, (i + 1) % 4); step(1);
        end
        check("ovf_count", count, 4);
        check("ovf_flag", ovf, 1);
        rd_req = 1'b1; step(1); rd_req = 1'b0;
        check("ovf_pop", rd_data, 8'hA9);

        // Pop on the tick of a full buffer, then pop while empty.
        clear = 1'b1; step(1); clear = 1'b0;
        for (int i = 0; i < 4; i++) begin wait_tick(); step(1); end
        wait_tick(); rd_req = 1'b1; step(1);
        check("full_pop_count", count, 4);
        check("full_pop_ovf", ovf, 0);
        step(4); step(1);
        check("empty_pop_v", rd_valid, 0);
        check("empty_pop_count", count, 0);
        rd_req = 1'b0;

        // Reset mid-interval with three entries stored.
        clear = 1'b1; step(1); clear = 1'b0;
        for (int i = 0; i < 3; i++) begin wait_tick(); step(1); end
        step(2);
        sens_in = {N_CH{2'd2}};
        rst_n = 1'b0; #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_filt", filt_out, 8'hAA);
        check("mid_rst_trend", trend_out, 8'hFF);
        step(1); rst_n = 1'b1;
        step(6); check("post_rst_no_tick", log_tick, 0);
        step(1); check("post_rst_tick", log_tick, 1);
        step(1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            ena = ($urandom_range(7) != 0);
            if ($urandom_range(9) == 0) set_ch($urandom_range(N_CH - 1), $urandom_range(3));
            rd_req = ($urandom_range(99) < ((i < 750) ? 8 : 35));
            clear  = ($urandom_range(79) == 0);
            step(1);
        end
        ena = 1'b0; rd_req = 1'b0; clear = 1'b0;
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ag_sensor_logger.md
AG_SENSOR_LOGGER -- requirements
Module: ag_sensor_logger

Interface
REQ-001 Parameter N_CH, 4, number of sensor channels (1..8).
REQ-002 Parameter W, 2, bits per sensor sample (2..8).
REQ-003 Parameter FILT_CNT, 100000, stable cycles required before a filtered value updates (>=1).
REQ-004 Parameter LOG_INTERVAL, 2500000, clk cycles between log ticks (>=2).
REQ-005 Parameter DEPTH, 8, ring-buffer entries, power of two (2..64).
REQ-006 Reset rst_n, asynchronous, active-low; clock clk.
REQ-007 clk  in  1  system clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 ena  in  1  enables the filter, log timer and logging; the read port ignores ena.
REQ-010 sens_in  in  N_CH*W  raw samples; channel k at bits [k*W +: W].
REQ-011 clear  in  1  synchronous clear of buffer, statistics and ovf.
REQ-012 filt_out  out  N_CH*W  debounced samples, same packing as sens_in.
REQ-013 log_tick  out  1  one-cycle pulse on each log event.
REQ-014 rd_req  in  1  pop the oldest entry.
REQ-015 rd_valid  out  1  rd_data is valid this cycle (single-cycle pulse).
REQ-016 rd_data  out  N_CH*W  popped entry.
REQ-017 count  out  clog2(DEPTH)+1  number of stored entries.
REQ-018 ovf  out  1  sticky flag: an unread entry was overwritten.
REQ-019 min_out, max_out  out  N_CH*W each  per-channel min/max of logged samples.
REQ-020 trend_out  out  2*N_CH  per-channel trend code.

Function
REQ-021 Each channel has a debouncer with prev register and counter. When in != prev: prev<=in and cnt<=0. When in == prev and cnt<FILT_CNT: cnt increments. When in == prev and cnt==FILT_CNT: filt<=in.
REQ-022 filt_out changes exactly FILT_CNT+2 enabled edges after a new stable value is first sampled. A glitch shorter than this leaves filt_out unchanged.
REQ-023 The log timer counts 0..LOG_INTERVAL-1 while ena=1 and wraps. log_tick is asserted for the cycle in which the timer equals LOG_INTERVAL-1.
REQ-024 On log_tick, the full filt_out vector is written at the write pointer, and the write pointer increments modulo DEPTH.
REQ-025 Full (count==DEPTH) with log_tick and no pop: the oldest entry is overwritten, the read pointer advances, count stays DEPTH, and ovf<=1.
REQ-026 rd_req with count>0: on the next cycle rd_valid=1 and rd_data=oldest entry; the read pointer advances and count decrements.
REQ-027 rd_req with count==0 is ignored: rd_valid=0 and no state changes.
REQ-028 Simultaneous log_tick and accepted pop: both occur and count is unchanged. When full, ovf is not set.
REQ-029 Statistics: the first log after reset or clear loads min=max=sample. Later logs update min and max with an unsigned compare.
REQ-030 Trend codes: 2'b11 = no previous log; 2'b01 = sample > previous logged sample; 2'b10 = sample < previous; 2'b00 = equal. The previous logged sample is held per channel and is independent of buffer contents or pops.
REQ-031 clear takes priority over log_tick and rd_req in the same cycle: pointers, count and ovf go to 0, trends go to 2'b11, and statistics are marked empty. Filter state and the log timer are unaffected.
REQ-032 While statistics are empty, min_out and max_out read as 0.

Reset
REQ-033 Reset values: filt and prev = 2^(W-1) per channel; counters 0; timer 0; pointers and count 0; ovf 0; rd_valid 0; rd_data 0; log_tick 0; trend 2'b11; statistics empty.
REQ-034 Reset asserted mid-operation discards all logged data immediately. The first log_tick after release occurs LOG_INTERVAL enabled cycles later.

Structure
REQ-035 Shared package ag_pkg holds the trend code constants (TREND_FLAT, TREND_UP, TREND_DOWN, TREND_NONE) and the mid-value function.
REQ-036 One sub-module, ag_debounce (parameters W and FILT_CNT), is instantiated N_CH times. Buffer storage is a flop array in the top level.

Verification (N_CH=4, W=2, FILT_CNT=4, LOG_INTERVAL=8, DEPTH=4)
REQ-037 Hold channel 0 at 3 from reset -> filt_out[1:0]=3 exactly 6 edges later. A 3-cycle pulse of 0 -> no change.
REQ-038 Run 4 ticks with ch0 = 1,2,2,0 -> count=4, min=0, max=2, trend=10. Four pops return entries in write order and rd_valid pulses each time.
REQ-039 Run 5 ticks with no reads -> count=4, ovf=1, and the first pop returns the 2nd logged entry.
REQ-040 Full buffer with rd_req on the log_tick cycle -> count=4 and ovf=0. Pop with count=0 -> rd_valid=0 and count=0.
REQ-041 Assert clear together with log_tick -> count=0, ovf=0, trend=11, min=max=0. The next tick loads min=max=sample.
REQ-042 Assert rst_n low mid-interval with count=3 -> all outputs return to reset values and filt_out=2 per channel. The first tick comes 8 cycles after release.
